// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: runs one issue-queue request at a time against the data SRAM and
// returns read data to the xbar, evicted lines to the BIU and credit pops to the issue queue.
module bank_sram_ctrl #(
  parameter int SRAM_LATENCY = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         iq_sc_valid_i,
  output logic         iq_sc_ready_o,
  input  logic [1:0]   iq_sc_channel_id_i,
  input  logic [2:0]   iq_sc_opcode_i,
  input  logic [6:0]   iq_sc_set_way_offset_i,
  input  logic [7:0]   iq_sc_wbuffer_id_i,
  input  logic [2:0]   iq_sc_xbar_rob_num_i,
  input  logic [1:0]   iq_sc_cacheline_state_offset0_i,
  input  logic [1:0]   iq_sc_cacheline_state_offset1_i,
  input  logic [127:0] iq_sc_linefill_data_offset0_i,
  input  logic [127:0] iq_sc_linefill_data_offset1_i,
  output logic         wbuf_rd_o,
  output logic [7:0]   wbuf_id_o,
  input  logic [127:0] wbuf_data_i,
  output logic         sram_cs_o,
  output logic         sram_we_o,
  output logic [6:0]   sram_addr_o,
  output logic [127:0] sram_wdata_o,
  input  logic [127:0] sram_rdata_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [1:0]   rsp_channel_id_o,
  output logic [2:0]   rsp_rob_num_o,
  output logic [127:0] rsp_data_o,
  output logic         wb_valid_o,
  input  logic         wb_ready_i,
  output logic [5:0]   wb_addr_o,
  output logic [255:0] wb_data_o,
  output logic [2:0]   channel_spw_pop_o
);

  typedef enum logic [3:0] {
    IDLE, WBUF, WR, RD, RD_WAIT, LF0, LF1, EV0, EV0_WAIT, EV1, EV1_WAIT, RSP, WB
  } state_e;

  localparam logic [2:0] WAIT_INIT = 3'(SRAM_LATENCY - 1);
  localparam logic [2:0] OP_WR = 3'd0;
  localparam logic [2:0] OP_RD = 3'd1;
  localparam logic [2:0] OP_LF = 3'd2;
  localparam logic [2:0] OP_EV = 3'd3;

  state_e         state_q;
  logic           ready_q;
  logic [1:0]     ch_q;
  logic [2:0]     rob_q;
  logic [6:0]     swo_q;
  logic [127:0]   half0_q;
  logic [127:0]   half1_q;
  logic [2:0]     cnt_q;
  logic           wbuf_rd_q;
  logic [7:0]     wbuf_id_q;
  logic           cs_q;
  logic           we_q;
  logic [6:0]     addr_q;
  logic [127:0]   wdata_q;
  logic           rsp_valid_q;
  logic [127:0]   rsp_data_q;
  logic           wb_valid_q;
  logic [5:0]     wb_addr_q;
  logic [255:0]   wb_data_q;
  logic [2:0]     pop_d;

  logic unused_cl_state;
  assign unused_cl_state = ^{iq_sc_cacheline_state_offset0_i, iq_sc_cacheline_state_offset1_i};

  // half0_q/half1_q hold linefill data, and are reused as the eviction capture buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      ch_q        <= '0;
      rob_q       <= '0;
      swo_q       <= '0;
      half0_q     <= '0;
      half1_q     <= '0;
      cnt_q       <= '0;
      wbuf_rd_q   <= 1'b0;
      wbuf_id_q   <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      wbuf_rd_q <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          // A dropped reserved opcode parks here for one cycle with ready low.
          ready_q <= 1'b1;
          if (ready_q && iq_sc_valid_i) begin
            ready_q   <= 1'b0;
            ch_q      <= iq_sc_channel_id_i;
            rob_q     <= iq_sc_xbar_rob_num_i;
            swo_q     <= iq_sc_set_way_offset_i;
            wbuf_id_q <= iq_sc_wbuffer_id_i;
            half0_q   <= iq_sc_linefill_data_offset0_i;
            half1_q   <= iq_sc_linefill_data_offset1_i;
            case (iq_sc_opcode_i)
              OP_WR: begin
                state_q   <= WBUF;
                wbuf_rd_q <= 1'b1;
              end
              OP_RD: begin
                state_q <= RD;
                cs_q    <= 1'b1;
                addr_q  <= iq_sc_set_way_offset_i;
              end
              OP_LF: begin
                state_q <= LF0;
                cs_q    <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= {iq_sc_set_way_offset_i[6:1], 1'b0};
                wdata_q <= iq_sc_linefill_data_offset0_i;
              end
              OP_EV: begin
                state_q <= EV0;
                cs_q    <= 1'b1;
                addr_q  <= {iq_sc_set_way_offset_i[6:1], 1'b0};
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        WBUF: begin
          state_q <= WR;
          cs_q    <= 1'b1;
          we_q    <= 1'b1;
          addr_q  <= swo_q;
        end
        WR: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        RD: begin
          state_q <= RD_WAIT;
          cnt_q   <= WAIT_INIT;
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) begin
            rsp_data_q  <= sram_rdata_i;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        LF0: begin
          state_q <= LF1;
          cs_q    <= 1'b1;
          we_q    <= 1'b1;
          addr_q  <= {swo_q[6:1], 1'b1};
          wdata_q <= half1_q;
        end
        LF1: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= swo_q[0] ? half1_q : half0_q;
        end
        EV0: begin
          state_q <= EV0_WAIT;
          cnt_q   <= WAIT_INIT;
        end
        EV0_WAIT: begin
          if (cnt_q == 3'd0) begin
            half0_q <= sram_rdata_i;
            state_q <= EV1;
            cs_q    <= 1'b1;
            addr_q  <= {swo_q[6:1], 1'b1};
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        EV1: begin
          state_q <= EV1_WAIT;
          cnt_q   <= WAIT_INIT;
        end
        EV1_WAIT: begin
          if (cnt_q == 3'd0) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= swo_q[6:1];
            wb_data_q  <= {sram_rdata_i, half0_q};
            state_q    <= WB;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            ready_q     <= 1'b1;
          end
        end
        WB: begin
          if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
            ready_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Credit release must land in the handshake cycle itself, so it is decoded from rsp_ready_i.
  always_comb begin
    pop_d = '0;
    if (rsp_valid_q && rsp_ready_i) begin
      case (ch_q)
        2'd0:    pop_d = 3'b001;
        2'd1:    pop_d = 3'b010;
        2'd2:    pop_d = 3'b100;
        default: pop_d = 3'b000;
      endcase
    end
  end

  assign iq_sc_ready_o     = ready_q;
  assign wbuf_rd_o         = wbuf_rd_q;
  assign wbuf_id_o         = wbuf_id_q;
  assign sram_cs_o         = cs_q;
  assign sram_we_o         = we_q;
  assign sram_addr_o       = addr_q;
  // Write-buffer data arrives in the WR cycle itself and goes straight to the array.
  assign sram_wdata_o      = (state_q == WR) ? wbuf_data_i : wdata_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_channel_id_o  = ch_q;
  assign rsp_rob_num_o     = rob_q;
  assign rsp_data_o        = rsp_data_q;
  assign wb_valid_o        = wb_valid_q;
  assign wb_addr_o         = wb_addr_q;
  assign wb_data_o         = wb_data_q;
  assign channel_spw_pop_o = pop_d;

endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Bench for bank_sram_ctrl: transaction-level reference model checked every cycle,
// plus directed literal checks on the key scenarios.
module tb_bank_sram_ctrl;

  localparam int LAT = 1;
  localparam logic [127:0] LO_W = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] HI_W = 128'h5555AAAA_3333CCCC_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] H0_W = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] H1_W = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] WB12 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEFD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         valid = 1'b0, valid3 = 1'b0;
  logic [1:0]   ch = '0;
  logic [2:0]   op = '0, rob = '0;
  logic [6:0]   swo = '0;
  logic [7:0]   wid = '0;
  logic [127:0] lf0 = '0, lf1 = '0;
  logic [127:0] wbuf_data = '0;
  logic [127:0] rdata = '0, rdata3;
  logic         rsp_ready = 1'b1, wb_ready = 1'b1;

  logic         ready, wbuf_rd, s_cs, s_we, rsp_valid, wb_valid;
  logic [7:0]   wbuf_id;
  logic [6:0]   s_addr;
  logic [127:0] s_wdata, rsp_data;
  logic [1:0]   rsp_ch;
  logic [2:0]   rsp_rob, pop;
  logic [5:0]   wb_addr;
  logic [255:0] wb_data;

  logic         ready3, wbuf_rd3, cs3, we3, rv3, wv3;
  logic [7:0]   wbuf_id3;
  logic [6:0]   addr3;
  logic [127:0] wdata3, rdat3o;
  logic [1:0]   rch3;
  logic [2:0]   rrob3, pop3;
  logic [5:0]   waddr3;
  logic [255:0] wbdat3;

  int n_tests = 0;
  int n_fail  = 0;

  bank_sram_ctrl #(.SRAM_LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .iq_sc_valid_i(valid), .iq_sc_ready_o(ready),
    .iq_sc_channel_id_i(ch), .iq_sc_opcode_i(op), .iq_sc_set_way_offset_i(swo),
    .iq_sc_wbuffer_id_i(wid), .iq_sc_xbar_rob_num_i(rob),
    .iq_sc_cacheline_state_offset0_i(2'b00), .iq_sc_cacheline_state_offset1_i(2'b11),
    .iq_sc_linefill_data_offset0_i(lf0), .iq_sc_linefill_data_offset1_i(lf1),
    .wbuf_rd_o(wbuf_rd), .wbuf_id_o(wbuf_id), .wbuf_data_i(wbuf_data),
    .sram_cs_o(s_cs), .sram_we_o(s_we), .sram_addr_o(s_addr), .sram_wdata_o(s_wdata),
    .sram_rdata_i(rdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_channel_id_o(rsp_ch),
    .rsp_rob_num_o(rsp_rob), .rsp_data_o(rsp_data),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .channel_spw_pop_o(pop)
  );

  bank_sram_ctrl #(.SRAM_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .iq_sc_valid_i(valid3), .iq_sc_ready_o(ready3),
    .iq_sc_channel_id_i(ch), .iq_sc_opcode_i(op), .iq_sc_set_way_offset_i(swo),
    .iq_sc_wbuffer_id_i(wid), .iq_sc_xbar_rob_num_i(rob),
    .iq_sc_cacheline_state_offset0_i(2'b00), .iq_sc_cacheline_state_offset1_i(2'b00),
    .iq_sc_linefill_data_offset0_i(lf0), .iq_sc_linefill_data_offset1_i(lf1),
    .wbuf_rd_o(wbuf_rd3), .wbuf_id_o(wbuf_id3), .wbuf_data_i(wbuf_data),
    .sram_cs_o(cs3), .sram_we_o(we3), .sram_addr_o(addr3), .sram_wdata_o(wdata3),
    .sram_rdata_i(rdata3),
    .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready), .rsp_channel_id_o(rch3),
    .rsp_rob_num_o(rrob3), .rsp_data_o(rdat3o),
    .wb_valid_o(wv3), .wb_ready_i(1'b1), .wb_addr_o(waddr3), .wb_data_o(wbdat3),
    .channel_spw_pop_o(pop3)
  );

  function automatic logic [127:0] init_word(input int a);
    case (a)
      5:       return {16{8'hA5}};
      32:      return LO_W;
      33:      return HI_W;
      default: return {16{8'(a)}};
    endcase
  endfunction

  function automatic logic [127:0] wfun(input logic [7:0] id);
    return {4{32'hDEADBEEF}} ^ {120'd0, id};
  endfunction

  task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Environment: latency-1 SRAM, latency-3 SRAM, write buffer.
  logic [127:0] sram_mem [128];
  logic [127:0] mem3 [128];
  logic [127:0] p3 [3];
  assign rdata3 = p3[2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) sram_mem[i] <= init_word(i);
      rdata <= '0;
    end else begin
      if (s_cs && s_we) sram_mem[s_addr] <= s_wdata;
      if (s_cs && !s_we) rdata <= sram_mem[s_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem3[i] <= init_word(i);
      for (int j = 0; j < 3; j++) p3[j] <= '0;
    end else begin
      if (cs3 && we3) mem3[addr3] <= wdata3;
      p3[0] <= (cs3 && !we3) ? mem3[addr3] : '0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end

  always @(posedge clk) if (wbuf_rd) wbuf_data <= wfun(wbuf_id);

  // Reference model: k counts cycles since acceptance; each opcode's visible schedule is listed.
  bit           m_busy = 1'b0;
  int           m_k = 0;
  logic [2:0]   m_op, m_rob;
  logic [1:0]   m_ch;
  logic [6:0]   m_swo;
  logic [7:0]   m_wid;
  logic [127:0] m_h0, m_h1, m_rd, m_e0, m_e1;
  logic [127:0] ref_mem [128];
  logic         e_ready, e_wrd, e_cs, e_we, e_rv, e_wv, done;
  logic [2:0]   e_pop;
  logic [6:0]   e_addr;
  logic [127:0] e_wdata, e_rdata;

  always @(negedge clk) begin
    e_ready = 1'b1; e_wrd = 1'b0; e_cs = 1'b0; e_we = 1'b0; e_rv = 1'b0; e_wv = 1'b0;
    e_pop = '0; e_addr = '0; e_wdata = '0; e_rdata = '0; done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
      chk("rst_ctrl", {ready, wbuf_rd, s_cs, s_we, rsp_valid, wb_valid, pop}, {1'b1, 8'd0});
      chk("rst_payload", {wbuf_id, s_addr, s_wdata, rsp_ch, rsp_rob, rsp_data}, '0);
      chk("rst_wb_payload", {wb_addr, wb_data}, '0);
    end else begin
      if (m_busy) begin
        e_ready = 1'b0;
        case (m_op)
          3'd0: begin
            if (m_k == 1) e_wrd = 1'b1;
            else if (m_k == 2) begin
              e_cs = 1'b1; e_we = 1'b1; e_addr = m_swo; e_wdata = wfun(m_wid); done = 1'b1;
            end
          end
          3'd1: begin
            if (m_k == 1) begin e_cs = 1'b1; e_addr = m_swo; end
            else if (m_k >= 2 + LAT) begin e_rv = 1'b1; e_rdata = m_rd; done = rsp_ready; end
          end
          3'd2: begin
            if (m_k == 1) begin
              e_cs = 1'b1; e_we = 1'b1; e_addr = {m_swo[6:1], 1'b0}; e_wdata = m_h0;
            end else if (m_k == 2) begin
              e_cs = 1'b1; e_we = 1'b1; e_addr = {m_swo[6:1], 1'b1}; e_wdata = m_h1;
            end else begin
              e_rv = 1'b1; e_rdata = m_swo[0] ? m_h1 : m_h0; done = rsp_ready;
            end
          end
          3'd3: begin
            if (m_k == 1) begin e_cs = 1'b1; e_addr = {m_swo[6:1], 1'b0}; end
            else if (m_k == 2 + LAT) begin e_cs = 1'b1; e_addr = {m_swo[6:1], 1'b1}; end
            else if (m_k >= 3 + 2 * LAT) begin e_wv = 1'b1; done = wb_ready; end
          end
          default: done = 1'b1;
        endcase
        if (e_rv && rsp_ready && m_ch != 2'd3) e_pop = 3'b001 << m_ch;
      end
      chk("model_ctrl", {ready, wbuf_rd, s_cs, s_we, rsp_valid, wb_valid, pop},
          {e_ready, e_wrd, e_cs, e_we, e_rv, e_wv, e_pop});
      if (e_wrd) chk("model_wbuf_id", wbuf_id, m_wid);
      if (e_cs) chk("model_sram_addr", s_addr, e_addr);
      if (e_we) chk("model_sram_wdata", s_wdata, e_wdata);
      if (e_rv) chk("model_rsp", {rsp_ch, rsp_rob, rsp_data}, {m_ch, m_rob, e_rdata});
      if (e_wv) chk("model_wb", {wb_addr, wb_data}, {m_swo[6:1], m_e1, m_e0});
      if (e_cs && e_we) ref_mem[e_addr] = e_wdata;
      if (!m_busy) begin
        if (valid) begin
          m_busy = 1'b1; m_k = 1;
          m_op = op; m_ch = ch; m_swo = swo; m_wid = wid; m_rob = rob; m_h0 = lf0; m_h1 = lf1;
          m_rd = ref_mem[swo];
          m_e0 = ref_mem[{swo[6:1], 1'b0}];
          m_e1 = ref_mem[{swo[6:1], 1'b1}];
        end
      end else if (done) begin
        m_busy = 1'b0;
      end else begin
        m_k++;
      end
    end
  end

  // Returns just after the acceptance edge, i.e. inside cycle T+1.
  task automatic issue(input bit use3, input logic [2:0] o, input logic [1:0] c,
                       input logic [6:0] s, input logic [7:0] w, input logic [2:0] r,
                       input logic [127:0] h0, input logic [127:0] h1, input bit rnd);
    bit acc;
    @(posedge clk); #1;
    op = o; ch = c; swo = s; wid = w; rob = r; lf0 = h0; lf1 = h1;
    if (use3) valid3 = 1'b1; else valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acc = use3 ? ready3 : ready;
      @(posedge clk); #1;
      if (rnd) begin
        rsp_ready = 1'($urandom_range(0, 1));
        wb_ready  = 1'($urandom_range(0, 1));
      end
      if (acc) begin
        valid = 1'b0; valid3 = 1'b0;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL issue_timeout: request op %0d not accepted within 60 cycles", o);
    valid = 1'b0; valid3 = 1'b0;
  endtask

  int ops [12] = '{0, 1, 2, 3, 1, 5, 2, 0, 3, 1, 7, 2};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 1'b1);
    chk("reset_outputs", {wbuf_rd, s_cs, s_we, rsp_valid, wb_valid, pop}, '0);
    @(posedge clk); #1 rst = 1'b0;

    // read, ch 1, rob 3, word 5
    issue(0, 3'd1, 2'd1, 7'h05, 8'h00, 3'd3, '0, '0, 0);
    @(negedge clk); chk("rd_strobe", {s_cs, s_we, s_addr}, {1'b1, 1'b0, 7'h05});
    @(negedge clk); chk("rd_no_rsp_yet", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rd_rsp", {rsp_valid, rsp_rob, rsp_data}, {1'b1, 3'd3, {16{8'hA5}}});
    chk("rd_pop", pop, 3'b010);
    @(negedge clk); chk("rd_ready_back", {ready, pop}, {1'b1, 3'b000});

    // write from wbuffer 0x12 to 0x7F
    issue(0, 3'd0, 2'd2, 7'h7F, 8'h12, 3'd0, '0, '0, 0);
    @(negedge clk); chk("wr_wbuf_rd", {wbuf_rd, wbuf_id}, {1'b1, 8'h12});
    @(negedge clk);
    chk("wr_strobe", {s_cs, s_we, s_addr}, {1'b1, 1'b1, 7'h7F});
    chk("wr_data", s_wdata, WB12);
    @(negedge clk);
    chk("wr_done", {ready, rsp_valid, pop}, {1'b1, 1'b0, 3'b000});
    chk("wr_mem", sram_mem[7'h7F], WB12);

    // linefill, ch 0, odd half requested
    issue(0, 3'd2, 2'd0, 7'h0B, 8'h00, 3'd5, H0_W, H1_W, 0);
    @(negedge clk);
    chk("lf0_strobe", {ready, s_cs, s_we, s_addr}, {1'b0, 1'b1, 1'b1, 7'h0A});
    chk("lf0_data", s_wdata, H0_W);
    @(negedge clk);
    chk("lf1_strobe", {ready, s_cs, s_we, s_addr}, {1'b0, 1'b1, 1'b1, 7'h0B});
    chk("lf1_data", s_wdata, H1_W);
    @(negedge clk);
    chk("lf_rsp", {ready, rsp_valid, rsp_rob, rsp_data}, {1'b0, 1'b1, 3'd5, H1_W});
    chk("lf_pop", pop, 3'b001);
    @(negedge clk); chk("lf_ready_back", ready, 1'b1);
    chk("lf_mem", {sram_mem[7'h0A], sram_mem[7'h0B]}, {H0_W, H1_W});

    // write back of line 0x10 with BIU stalled 5 cycles
    wb_ready = 1'b0;
    issue(0, 3'd3, 2'd1, 7'h20, 8'h00, 3'd0, '0, '0, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wb_hold", {wb_valid, wb_addr, wb_data}, {1'b1, 6'h10, HI_W, LO_W});
      chk("wb_no_pop", {rsp_valid, pop}, '0);
    end
    @(posedge clk); #1 wb_ready = 1'b1;
    @(negedge clk); chk("wb_handshake", wb_valid, 1'b1);
    @(negedge clk); chk("wb_done", {ready, wb_valid}, {1'b1, 1'b0});

    // read on ch 3 with xbar stalled, then reset during the response
    rsp_ready = 1'b0;
    issue(0, 3'd1, 2'd3, 7'h7F, 8'h00, 3'd6, '0, '0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_ch, rsp_rob, rsp_data}, {1'b1, 2'd3, 3'd6, WB12});
      chk("rsp_hold_pop", pop, 3'b000);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("mid_reset", {rsp_valid, ready, pop, wb_valid}, {1'b0, 1'b1, 3'b000, 1'b0});
    @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;

    // read on ch 2 after reset
    issue(0, 3'd1, 2'd2, 7'h05, 8'h00, 3'd1, '0, '0, 0);
    repeat (2) @(negedge clk);
    @(negedge clk); chk("ch2_pop", {rsp_valid, pop}, {1'b1, 3'b100});

    // reserved opcode is dropped
    issue(0, 3'd5, 2'd1, 7'h33, 8'h00, 3'd0, '0, '0, 0);
    @(negedge clk); chk("drop_busy", {ready, s_cs, wbuf_rd}, 3'b000);
    @(negedge clk); chk("drop_ready", {ready, s_cs, rsp_valid, wb_valid}, 4'b1000);

    // latency-3 instance read
    issue(1, 3'd1, 2'd1, 7'h05, 8'h00, 3'd2, '0, '0, 0);
    @(negedge clk); chk("lat3_strobe", {cs3, we3, addr3}, {1'b1, 1'b0, 7'h05});
    repeat (2) @(negedge clk);
    @(negedge clk); chk("lat3_not_yet", rv3, 1'b0);
    @(negedge clk);
    chk("lat3_rsp", {rv3, rrob3, rdat3o}, {1'b1, 3'd2, {16{8'hA5}}});
    chk("lat3_pop", pop3, 3'b010);

    // mixed traffic with random stalls, checked by the model
    for (int i = 0; i < 12; i++) begin
      issue(0, 3'(ops[i]), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
            8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
            {4{32'($urandom)}}, {4{32'($urandom)}}, 1);
    end
    rsp_ready = 1'b1; wb_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk); chk("drain_idle", {ready, rsp_valid, wb_valid}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
